uart_tx: RTL and testbench



---
 rtl/uart_tx_if.sv | 45 ++++
 rtl/uart_tx.sv | 130 +++++++++++++
 tb/tb_uart_tx.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_if.sv
`default_nettype none
// ============================================================================
// Module      : phy_types_pkg / uart_tx_if
// Description : Shared PHY frame-type encoding and the request/status bundle
//               between a frame source and the multi-lane UART transmitter.
// Revision    : 1.0 - initial release
// ============================================================================

package phy_types_pkg;
    // NADA is the "no frame" encoding; requesting it is an error.
    typedef enum logic [1:0] {
        NADA                = 2'd0,
        SELECT_COMMA_1_FLIT = 2'd1,
        SELECT_COMMA_2_FLIT = 2'd2,
        SELECT_COMMA_DATA   = 2'd3
    } comma_sel_t;
endpackage

interface uart_tx_if #(
    parameter int PORTCOUNT = 5
);
    import phy_types_pkg::*;

    logic                     start;
    comma_sel_t               comma_sel;
    logic [10*PORTCOUNT-1:0]  data;
    logic [PORTCOUNT-1:0]     uart_out;
    logic                     busy;
    logic                     done;
    logic                     tx_err;

    // Frame source side
    modport master (
        output start, comma_sel, data,
        input  uart_out, busy, done, tx_err
    );

    // Transmitter side
    modport slave (
        input  start, comma_sel, data,
        output uart_out, busy, done, tx_err
    );
endinterface

`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx
// Description : Multi-lane UART transmitter. Sends a start bit, N data slices
//               (N = 2, 4 or 10 by frame type) and a stop bit across
//               PORTCOUNT lanes, one slice per bit period.
// Revision    : 1.0 - initial release
// ============================================================================

module uart_tx #(
    parameter int PORTCOUNT    = 5,
    parameter int CLKDIV_COUNT = 10
) (
    input  wire        CLK,
    input  wire        RST,
    uart_tx_if.slave   bus
);
    import phy_types_pkg::*;

    localparam int TW = (CLKDIV_COUNT > 2) ? $clog2(CLKDIV_COUNT) : 1;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] START = 3'd1;
    localparam logic [2:0] SEND  = 3'd2;
    localparam logic [2:0] STOP  = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    logic [2:0]              state, state_next;
    logic [TW-1:0]           timer, timer_next;
    logic [3:0]              slice, slice_next;
    logic                    capture;
    logic [10*PORTCOUNT-1:0] data_q;
    comma_sel_t              sel_q;
    logic [3:0]              last_slice;
    logic                    expire;

    logic [PORTCOUNT-1:0]    uart_out_next;
    logic                    busy_next;
    logic                    done_next;
    logic                    tx_err_next;

    assign expire = (timer == TW'(CLKDIV_COUNT - 1));

    // Index of the final data slice for the captured frame type
    always_comb begin
        case (sel_q)
            SELECT_COMMA_1_FLIT: last_slice = 4'd1;
            SELECT_COMMA_2_FLIT: last_slice = 4'd3;
            default:             last_slice = 4'd9;
        endcase
    end

    // State, counters, holding registers and registered outputs
    always_ff @(posedge CLK) begin
        if (RST) begin
            state        <= IDLE;
            timer        <= '0;
            slice        <= '0;
            data_q       <= '0;
            sel_q        <= NADA;
            bus.uart_out <= '1;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
            bus.tx_err   <= 1'b0;
        end else begin
            state        <= state_next;
            timer        <= timer_next;
            slice        <= slice_next;
            if (capture) begin
                data_q <= bus.data;
                sel_q  <= bus.comma_sel;
            end
            bus.uart_out <= uart_out_next;
            bus.busy     <= busy_next;
            bus.done     <= done_next;
            bus.tx_err   <= tx_err_next;
        end
    end

    // Next-state, bit-period timer and slice counter
    always_comb begin
        state_next = state;
        timer_next = timer;
        slice_next = slice;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start && (bus.comma_sel != NADA)) begin
                    state_next = START;
                    timer_next = '0;
                    slice_next = '0;
                    capture    = 1'b1;
                end
            end
            START: begin
                timer_next = expire ? '0 : timer + 1'b1;
                if (expire) state_next = SEND;
            end
            SEND: begin
                timer_next = expire ? '0 : timer + 1'b1;
                if (expire) begin
                    if (slice == last_slice) state_next = STOP;
                    else                     slice_next = slice + 4'd1;
                end
            end
            STOP: begin
                timer_next = expire ? '0 : timer + 1'b1;
                if (expire) state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output values for the coming cycle, derived from the next state
    always_comb begin
        uart_out_next = '1;
        busy_next     = (state_next != IDLE);
        done_next     = (state_next == DONE);
        tx_err_next   = (state == IDLE) && bus.start && (bus.comma_sel == NADA);
        case (state_next)
            START:   uart_out_next = '0;
            SEND:    uart_out_next = data_q[int'(slice_next) * PORTCOUNT +: PORTCOUNT];
            default: uart_out_next = '1;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx
// Description : Self-checking bench for uart_tx with a frame-level reference
//               model (expected lane values computed per cycle offset).
// Revision    : 1.0 - initial release
// ============================================================================

module tb_uart_tx;
    import phy_types_pkg::*;

    localparam int P = 5;
    localparam int D = 10;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    uart_tx_if #(.PORTCOUNT(P)) bus();

    uart_tx #(.PORTCOUNT(P), .CLKDIV_COUNT(D)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int n_of(input comma_sel_t s);
        case (s)
            SELECT_COMMA_1_FLIT: return 2;
            SELECT_COMMA_2_FLIT: return 4;
            default:             return 10;
        endcase
    endfunction

    // Payload where every slice is neither all-zeros nor all-ones
    function automatic logic [10*P-1:0] rand_data();
        logic [10*P-1:0] d;
        d = '0;
        for (int k = 0; k < 10; k++) d[k*P +: P] = P'($urandom_range(1, (1 << P) - 2));
        return d;
    endfunction

    // Reference: lane value and status c cycles after the accepting edge
    task automatic frame_expect(input int c, input int n, input logic [10*P-1:0] cap,
                                output logic [P-1:0] uo, output logic bz, output logic dn);
        bz = 1'b1;
        dn = 1'b0;
        if (c <= D)               uo = '0;
        else if (c <= (n + 1) * D) uo = cap[((c - D - 1) / D) * P +: P];
        else if (c <= (n + 2) * D) uo = '1;
        else begin
            uo = '1;
            dn = 1'b1;
        end
    endtask

    task automatic check_frame_cycle(input string tag, input int c, input int n,
                                     input logic [10*P-1:0] cap);
        logic [P-1:0] uo;
        logic bz, dn;
        frame_expect(c, n, cap, uo, bz, dn);
        chk({tag, "_uart_out"}, 64'(bus.uart_out), 64'(uo));
        chk({tag, "_busy"},     64'(bus.busy),     64'(bz));
        chk({tag, "_done"},     64'(bus.done),     64'(dn));
        chk({tag, "_tx_err"},   64'(bus.tx_err),   64'd0);
    endtask

    // Send one frame and check every cycle through DONE
    task automatic send_frame(input string tag, input comma_sel_t sel, input logic [10*P-1:0] d,
                              input bit hold, input bit scramble);
        int n;
        @(negedge CLK);
        bus.start     = 1'b1;
        bus.comma_sel = sel;
        bus.data      = d;
        @(posedge CLK);
        n = n_of(sel);
        for (int c = 1; c <= (n + 2) * D + 1; c++) begin
            @(negedge CLK);
            if (!hold)    bus.start = 1'b0;
            if (scramble) bus.data  = {$urandom, $urandom};
            check_frame_cycle(tag, c, n, d);
        end
    endtask

    initial begin
        logic [10*P-1:0] d;
        bit seen;

        bus.start     = 1'b0;
        bus.comma_sel = NADA;
        bus.data      = '0;

        // 1. reset then idle
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            chk("idle_uart_out", 64'(bus.uart_out), 64'h1f);
            chk("idle_busy",     64'(bus.busy),     64'd0);
            chk("idle_done",     64'(bus.done),     64'd0);
            chk("idle_tx_err",   64'(bus.tx_err),   64'd0);
        end

        // 2. two-slice frame with fixed pattern
        d = rand_data();
        d[4:0] = 5'b10101;
        d[9:5] = 5'b01010;
        send_frame("f1flit", SELECT_COMMA_1_FLIT, d, 1'b0, 1'b0);

        // 3. ten-slice frame, start held high throughout
        d = rand_data();
        send_frame("fdata", SELECT_COMMA_DATA, d, 1'b1, 1'b0);
        @(negedge CLK);
        chk("fdata_gap_uart_out", 64'(bus.uart_out), 64'h1f);
        chk("fdata_gap_busy",     64'(bus.busy),     64'd0);
        @(negedge CLK);
        chk("fdata_next_start_uart_out", 64'(bus.uart_out), 64'h00);
        chk("fdata_next_start_busy",     64'(bus.busy),     64'd1);
        bus.start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge CLK);
            if (bus.done) seen = 1'b1;
        end
        chk("fdata_second_done_seen", 64'(seen), 64'd1);
        repeat (2) @(negedge CLK);

        // 4. four-slice frame, data scrambled every cycle
        d = rand_data();
        send_frame("f2flit", SELECT_COMMA_2_FLIT, d, 1'b0, 1'b1);
        @(negedge CLK);

        // 5. illegal frame type
        bus.start     = 1'b1;
        bus.comma_sel = NADA;
        bus.data      = rand_data();
        @(posedge CLK);
        @(negedge CLK);
        bus.start = 1'b0;
        chk("nada_tx_err",   64'(bus.tx_err),   64'd1);
        chk("nada_uart_out", 64'(bus.uart_out), 64'h1f);
        chk("nada_busy",     64'(bus.busy),     64'd0);
        @(negedge CLK);
        chk("nada_tx_err_clear", 64'(bus.tx_err),   64'd0);
        chk("nada_busy_after",   64'(bus.busy),     64'd0);
        chk("nada_uart_after",   64'(bus.uart_out), 64'h1f);

        // 6. reset during slice 1 of a data frame
        d = rand_data();
        bus.start     = 1'b1;
        bus.comma_sel = SELECT_COMMA_DATA;
        bus.data      = d;
        @(posedge CLK);
        for (int c = 1; c <= 25; c++) begin
            @(negedge CLK);
            bus.start = 1'b0;
            check_frame_cycle("frst", c, 10, d);
        end
        RST       = 1'b1;
        bus.start = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        chk("rst_uart_out", 64'(bus.uart_out), 64'h1f);
        chk("rst_busy",     64'(bus.busy),     64'd0);
        chk("rst_done",     64'(bus.done),     64'd0);
        RST       = 1'b0;
        bus.start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            chk("post_rst_done",     64'(bus.done),     64'd0);
            chk("post_rst_busy",     64'(bus.busy),     64'd0);
            chk("post_rst_uart_out", 64'(bus.uart_out), 64'h1f);
        end
        d = rand_data();
        send_frame("fafter", SELECT_COMMA_1_FLIT, d, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
